bcd_display_scanner: RTL

//  Time-multiplexed driver for N_DIGITS common-anode 7-segment digits from a packed BCD word.

---
 rtl/display_pkg.sv | 18 +
 rtl/bcd_seg_decoder.sv | 11 +
 rtl/bcd_display_scanner.sv | 91 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared 7-segment constants and BCD-to-segment decode
//   SEG_W      segment count (a..g)
//   seg_t      active-low segment vector, bit 0 = a
//   SEG_BLANK  all segments off
//   SEG_TABLE  active-low patterns for digits 0..9
//   bcd_seg    decode one BCD code, invalid codes (>9) give SEG_BLANK
package display_pkg;
   localparam int SEG_W = 7;
   typedef logic [0:SEG_W-1] seg_t;
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_TABLE [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };
   function automatic seg_t bcd_seg(input logic [3:0] code);
      return (code > 4'd9) ? SEG_BLANK : SEG_TABLE[code];
   endfunction
endpackage

// File: rtl/bcd_seg_decoder.sv
// bcd_seg_decoder: combinational BCD to active-low 7-segment decoder
//   code  in   4      BCD digit, codes above 9 decode to blank
//   seg   out  [0:6]  segments a..g, active-low
module bcd_seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] code,
   output seg_t       seg
);
   assign seg = bcd_seg(code);
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexed common-anode 7-segment scanner for a packed BCD word
//   clk        in   1           system clock
//   rst        in   1           synchronous active-high reset
//   load       in   1           latch bcd_in, dp_in, blink_en
//   bcd_in     in   4*N_DIGITS  digit i at bits [4i+3:4i]
//   dp_in      in   N_DIGITS    decimal point request per digit, 1 = lit
//   blink_en   in   N_DIGITS    1 = digit blinks
//   blank_lz   in   1           suppress leading zeros (live)
//   seg        out  [0:6]       segments a..g, active-low
//   dp         out  1           decimal point, active-low
//   an         out  N_DIGITS    digit enables, active-low
//   frame_tick out  1           pulse when the last digit slot ends
module bcd_display_scanner
   import display_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int SLOT_CLKS = 50000,
   parameter int BLINK_FRM = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blink_en,
   input  logic                  blank_lz,
   output logic [0:SEG_W-1]      seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_tick
);
   localparam int PW = $clog2(SLOT_CLKS);
   localparam int IW = $clog2(N_DIGITS);
   localparam int FW = BLINK_FRM > 1 ? $clog2(BLINK_FRM) : 1;
   logic [PW-1:0]         psc;
   logic [IW-1:0]         idx;
   logic [FW-1:0]         frm;
   logic                  phase;
   logic [4*N_DIGITS-1:0] bcd_r;
   logic [N_DIGITS-1:0]   dp_r, blink_r, zero, lz;
   logic [3:0]            code;
   seg_t                  dec;
   logic                  slot_end, wrap, frm_last, blank;
   // lz[i]: digit i and every digit above it are zero; bits below i are forced
   // to 1 so the AND-reduce only sees the suffix. Digit 0 is never suppressed.
   always_comb begin
      zero = '0;
      lz   = '0;
      for (int i = 0; i < N_DIGITS; i++) zero[i] = bcd_r[4*i +: 4] == 4'd0;
      for (int i = 1; i < N_DIGITS; i++) lz[i] = &(zero | N_DIGITS'((1 << i) - 1));
   end
   assign code     = bcd_r[4*idx +: 4];
   assign slot_end = psc == PW'(SLOT_CLKS - 1);
   assign wrap     = slot_end && idx == IW'(N_DIGITS - 1);
   assign frm_last = frm == FW'(BLINK_FRM - 1);
   assign blank    = (blink_r[idx] & phase) | (blank_lz & lz[idx]);
   bcd_seg_decoder u_dec (
      .code (code),
      .seg  (dec)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         psc        <= '0;
         idx        <= '0;
         frm        <= '0;
         phase      <= 1'b0;
         bcd_r      <= '0;
         dp_r       <= '0;
         blink_r    <= '0;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         an         <= '1;
         frame_tick <= 1'b0;
      end else begin
         if (load) begin
            bcd_r   <= bcd_in;
            dp_r    <= dp_in;
            blink_r <= blink_en;
         end
         psc        <= slot_end ? '0 : psc + 1'b1;
         idx        <= wrap ? '0 : slot_end ? idx + 1'b1 : idx;
         frm        <= wrap ? (frm_last ? '0 : frm + 1'b1) : frm;
         phase      <= phase ^ (wrap & frm_last);
         frame_tick <= wrap;
         // first cycle of each slot keeps all anodes off to avoid ghosting
         an         <= psc == '0 ? '1 : ~(N_DIGITS'(1) << idx);
         seg        <= blank ? SEG_BLANK : dec;
         dp         <= blank | ~dp_r[idx];
      end
   end
endmodule
